// File: rtl/arithmetic_left_shift_serial_pkg.sv
// Shared definitions for the shift blocks: FSM state type and default operand sizes.
package arithmetic_left_shift_serial_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  localparam int unsigned DEFAULT_WIDTH = 8;
  localparam int unsigned DEFAULT_SHW   = 4;

endpackage

// File: rtl/arithmetic_left_shift_serial_if.sv
// Start/done request bus of the serial arithmetic left shifter.
interface arithmetic_left_shift_serial_if #(
  parameter int unsigned WIDTH = arithmetic_left_shift_serial_pkg::DEFAULT_WIDTH,
  parameter int unsigned SHW   = arithmetic_left_shift_serial_pkg::DEFAULT_SHW
);

  logic             start;
  logic [WIDTH-1:0] A;
  logic [SHW-1:0]   Shift_value;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] Arithmetic_left_shift_Output;
  logic             overflow;

  modport master (
    output start, A, Shift_value,
    input  busy, done, Arithmetic_left_shift_Output, overflow
  );

  modport slave (
    input  start, A, Shift_value,
    output busy, done, Arithmetic_left_shift_Output, overflow
  );

endinterface

// File: rtl/arithmetic_left_shift_serial.sv
// Serial arithmetic left shifter: one bit per clock, sticky signed-overflow detection,
// start/done handshake. Result and overflow hold until the next completion.
module arithmetic_left_shift_serial
  import arithmetic_left_shift_serial_pkg::*;
#(
  parameter int unsigned WIDTH = DEFAULT_WIDTH,
  parameter int unsigned SHW   = DEFAULT_SHW
) (
  input  logic                           clk,
  input  logic                           rst_n,
  arithmetic_left_shift_serial_if.slave  bus
);

  state_t           state, state_nx;
  logic [WIDTH-1:0] work, work_nx;
  logic [SHW-1:0]   count, count_nx;
  logic             sticky, sticky_nx;
  logic [WIDTH-1:0] result, result_nx;
  logic             ovf, ovf_nx;
  logic             busy_q, done_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= IDLE;
      work   <= '0;
      count  <= '0;
      sticky <= 1'b0;
      result <= '0;
      ovf    <= 1'b0;
      busy_q <= 1'b0;
      done_q <= 1'b0;
    end else begin
      state  <= state_nx;
      work   <= work_nx;
      count  <= count_nx;
      sticky <= sticky_nx;
      result <= result_nx;
      ovf    <= ovf_nx;
      // busy/done registered from the next state so they track the state register exactly
      busy_q <= (state_nx != IDLE);
      done_q <= (state_nx == DONE);
    end
  end

  always_comb begin
    state_nx  = state;
    work_nx   = work;
    count_nx  = count;
    sticky_nx = sticky;
    result_nx = result;
    ovf_nx    = ovf;
    unique case (state)
      IDLE: begin
        if (bus.start) begin
          work_nx   = bus.A;
          count_nx  = bus.Shift_value;
          sticky_nx = 1'b0;
          state_nx  = SHIFT;
        end
      end
      SHIFT: begin
        if (count == '0) begin
          result_nx = work;
          ovf_nx    = sticky;
          state_nx  = DONE;
        end else begin
          // sign bit would change on this step
          sticky_nx = sticky | (work[WIDTH-1] ^ work[WIDTH-2]);
          work_nx   = {work[WIDTH-2:0], 1'b0};
          count_nx  = count - SHW'(1);
        end
      end
      DONE: begin
        state_nx = IDLE;
      end
      default: begin
        state_nx = IDLE;
      end
    endcase
  end

  assign bus.busy                         = busy_q;
  assign bus.done                         = done_q;
  assign bus.Arithmetic_left_shift_Output = result;
  assign bus.overflow                     = ovf;

endmodule

// File: tb/tb_arithmetic_left_shift_serial.sv
// Bench for arithmetic_left_shift_serial: arithmetic reference model checked every cycle,
// plus directed operations with hand-computed results and latencies.
module tb_arithmetic_left_shift_serial;

  logic clk;
  logic rst_n;
  int   checks;
  int   errors;

  arithmetic_left_shift_serial_if #(.WIDTH(8), .SHW(4)) bus ();

  arithmetic_left_shift_serial #(.WIDTH(8), .SHW(4)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference: signed product A*2^n; overflow when it leaves the 8-bit signed range.
  function automatic void ref_shift(input logic [7:0] a, input logic [3:0] n,
                                    output logic [7:0] res, output logic ov);
    longint v;
    v   = longint'($signed(a));
    v   = v * (longint'(1) <<< n);
    res = v[7:0];
    ov  = (v > 127) || (v < -128);
  endfunction

  // Transaction-level model: accepted request completes n+1 edges later.
  logic       m_busy, m_done, m_ov, p_ov;
  logic [7:0] m_res, p_res;
  int         m_left;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_busy <= 1'b0;
      m_done <= 1'b0;
      m_res  <= '0;
      m_ov   <= 1'b0;
      m_left <= 0;
    end else begin
      m_done <= 1'b0;
      if (!m_busy) begin
        if (bus.start) begin
          logic [7:0] r;
          logic       o;
          ref_shift(bus.A, bus.Shift_value, r, o);
          p_res  <= r;
          p_ov   <= o;
          m_busy <= 1'b1;
          m_left <= int'(bus.Shift_value) + 1;
        end
      end else if (m_done) begin
        m_busy <= 1'b0;
      end else if (m_left == 1) begin
        m_done <= 1'b1;
        m_res  <= p_res;
        m_ov   <= p_ov;
        m_left <= 0;
      end else begin
        m_left <= m_left - 1;
      end
    end
  end

  always @(negedge clk) begin
    check("busy", 32'(bus.busy), 32'(m_busy));
    check("done", 32'(bus.done), 32'(m_done));
    check("result", 32'(bus.Arithmetic_left_shift_Output), 32'(m_res));
    check("overflow", 32'(bus.overflow), 32'(m_ov));
  end

  task automatic run_op(input logic [7:0] a, input logic [3:0] n,
                        input logic [7:0] exp_res, input logic exp_ov,
                        input int exp_lat, input bit inject);
    int lat;
    int extra;
    lat = -1;
    @(negedge clk);
    bus.start       = 1'b1;
    bus.A           = a;
    bus.Shift_value = n;
    @(posedge clk);
    @(negedge clk);
    bus.start       = 1'b0;
    bus.A           = 8'h5A;
    bus.Shift_value = 4'h7;
    for (int k = 1; k <= 40; k++) begin
      @(posedge clk);
      @(negedge clk);
      if (inject && k == 1) begin
        bus.start       = 1'b1;
        bus.A           = 8'h01;
        bus.Shift_value = 4'h1;
      end else begin
        bus.start = 1'b0;
      end
      if (k < exp_lat) check("busy_hold", 32'(bus.busy), 32'd1);
      if (bus.done) begin
        lat = k;
        break;
      end
    end
    if (lat < 0) begin
      errors++;
      $display("FAIL timeout: no done for A=%0h n=%0d", a, n);
    end
    check("latency", 32'(lat), 32'(exp_lat));
    check("lit_result", 32'(bus.Arithmetic_left_shift_Output), 32'(exp_res));
    check("lit_overflow", 32'(bus.overflow), 32'(exp_ov));
    extra = 0;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      if (bus.done) extra++;
    end
    check("extra_done", 32'(extra), 32'd0);
  endtask

  initial begin
    checks          = 0;
    errors          = 0;
    rst_n           = 1'b0;
    bus.start       = 1'b0;
    bus.A           = '0;
    bus.Shift_value = '0;
    repeat (3) @(negedge clk);
    check("rst_busy", 32'(bus.busy), 32'd0);
    check("rst_done", 32'(bus.done), 32'd0);
    check("rst_result", 32'(bus.Arithmetic_left_shift_Output), 32'd0);
    check("rst_overflow", 32'(bus.overflow), 32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    run_op(8'b0011_0011, 4'd2,  8'b1100_1100, 1'b1, 3,  1'b0);
    run_op(8'b1111_0000, 4'd3,  8'b1000_0000, 1'b0, 4,  1'b0);
    run_op(8'b1010_1010, 4'd0,  8'b1010_1010, 1'b0, 1,  1'b0);
    run_op(8'b0000_0001, 4'd8,  8'b0000_0000, 1'b1, 9,  1'b0);
    run_op(8'b0000_0000, 4'd9,  8'b0000_0000, 1'b0, 10, 1'b0);
    run_op(8'b1111_1111, 4'd15, 8'b0000_0000, 1'b1, 16, 1'b0);
    run_op(8'b1100_0000, 4'd1,  8'b1000_0000, 1'b0, 2,  1'b0);
    run_op(8'b0100_0000, 4'd1,  8'b1000_0000, 1'b1, 2,  1'b0);
    run_op(8'b1111_0000, 4'd3,  8'b1000_0000, 1'b0, 4,  1'b1);

    // Abort mid-operation; outputs must clear immediately.
    run_op(8'b0000_0011, 4'd1,  8'b0000_0110, 1'b0, 2,  1'b0);
    @(negedge clk);
    bus.start       = 1'b1;
    bus.A           = 8'hFF;
    bus.Shift_value = 4'd15;
    @(negedge clk);
    bus.start = 1'b0;
    repeat (3) @(negedge clk);
    check("mid_busy", 32'(bus.busy), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    check("abort_busy", 32'(bus.busy), 32'd0);
    check("abort_done", 32'(bus.done), 32'd0);
    check("abort_result", 32'(bus.Arithmetic_left_shift_Output), 32'd0);
    check("abort_overflow", 32'(bus.overflow), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (20) @(negedge clk);
    run_op(8'b0000_0001, 4'd1,  8'b0000_0010, 1'b0, 2,  1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
